// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg : shared types and constants for the instruction fetch queue
// Revision  : 1.0
// ============================================================================
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  localparam int unsigned PC_STEP   = 2;
  localparam int unsigned ENTRY_PCW = 32;
  localparam int unsigned ENTRY_IW  = 16;

  typedef struct packed {
    logic [ENTRY_PCW-1:0] pc;
    logic [ENTRY_IW-1:0]  instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// fetch_fifo : circular buffer of fetched {pc, instr} entries, head exposed
// Revision   : 1.0
// ============================================================================
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 48,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  input  logic          clear_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue : instruction fetch FSM with credit-based prefetch queue
// Revision    : 1.0
// ============================================================================
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned PCW   = 32,
  parameter int unsigned IW    = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [PCW-1:0] pc_in,
  output logic           pc_stall,
  input  logic           flush,
  input  logic           halt,
  output logic           mem_req,
  output logic [PCW-1:0] mem_addr,
  input  logic           mem_ack,
  input  logic           mem_rvalid,
  input  logic [IW-1:0]  mem_rdata,
  output logic           dec_valid,
  output logic [IW-1:0]  dec_instr,
  output logic [PCW-1:0] dec_pc,
  input  logic           dec_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = PCW + IW;
  localparam logic [CW:0] DEPTH_OCC = (CW+1)'(DEPTH);

  fetch_state_e   state_q;
  fetch_state_e   state_d;
  logic [PCW-1:0] tag_q;
  logic [CW-1:0]  count;
  logic [EW-1:0]  head;
  logic [CW:0]    occupancy;
  logic           in_idle;
  logic           in_wait;
  logic           accept;
  logic           push;
  logic           pop;

  assign in_idle = (state_q == S_IDLE);
  assign in_wait = (state_q == S_WAIT);

  // The outstanding request holds a slot so its response always fits.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, in_wait};

  assign mem_req  = rst_n & ~flush & ~halt & (occupancy < DEPTH_OCC)
                  & (in_idle | (in_wait & mem_rvalid));
  assign mem_addr = pc_in;
  assign accept   = mem_req & mem_ack;
  assign pc_stall = ~accept;

  assign push      = in_wait & mem_rvalid & ~flush;
  assign dec_valid = rst_n & (count != '0);
  assign pop       = dec_valid & dec_ready & ~flush;
  assign dec_pc    = head[EW-1:IW];
  assign dec_instr = head[IW-1:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (flush)           state_d = mem_rvalid ? S_IDLE : S_DRAIN;
        else if (mem_rvalid) state_d = accept ? S_WAIT : S_IDLE;
      end
      S_DRAIN: begin
        if (mem_rvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) tag_q <= pc_in;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  ({tag_q, mem_rdata}),
    .pop_i   (pop),
    .clear_i (flush),
    .head_o  (head),
    .count_o (count)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// tb_fetch_queue : directed stimulus with scoreboard-checked decode stream
// Revision       : 1.0
// ============================================================================
module tb_fetch_queue;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_in;
  logic        pc_stall;
  logic        flush;
  logic        halt;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        dec_valid;
  logic [15:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_ready;

  logic        auto_mem;
  logic        rv_keep;
  logic [31:0] rv_pc;
  logic [31:0] target;

  int n_tests = 0;
  int n_fail  = 0;
  fetch_entry_t exp_q[$];

  fetch_queue #(.PCW(32), .IW(16), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_in      (pc_in),
    .pc_stall   (pc_stall),
    .flush      (flush),
    .halt       (halt),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .dec_valid  (dec_valid),
    .dec_instr  (dec_instr),
    .dec_pc     (dec_pc),
    .dec_ready  (dec_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] instr_of(input logic [31:0] a);
    return a[15:0] ^ 16'h5A3C;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: sample at negedge, then act as PC and memory after posedge.
  task automatic step();
    logic        acc;
    logic        adv;
    logic        fl;
    logic [31:0] a;
    @(negedge clk);
    acc = mem_req & mem_ack;
    adv = ~pc_stall;
    fl  = flush;
    a   = mem_addr;
    if (mem_rvalid && rv_keep && !flush && rst_n)
      exp_q.push_back('{pc: rv_pc, instr: mem_rdata});
    if (fl || !rst_n) exp_q.delete();
    @(posedge clk);
    #1;
    if (fl)       pc_in = target;
    else if (adv) pc_in = pc_in + PC_STEP;
    if (auto_mem) begin
      mem_rvalid = acc;
      rv_keep    = acc;
      rv_pc      = a;
      mem_rdata  = acc ? instr_of(a) : 16'h0000;
    end
  endtask

  initial begin : monitor
    fetch_entry_t e;
    forever begin
      @(negedge clk);
      if (rst_n && !flush && dec_valid && dec_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL pop_unexpected: dec_pc 0x%0h, expected no entry", dec_pc);
        end else begin
          e = exp_q.pop_front();
          check("dec_pc", dec_pc, e.pc);
          check("dec_instr", {16'h0, dec_instr}, {16'h0, e.instr});
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    rst_n = 1'b0; pc_in = 32'h0; flush = 1'b0; halt = 1'b0;
    mem_ack = 1'b1; mem_rvalid = 1'b0; mem_rdata = 16'h0; dec_ready = 1'b1;
    auto_mem = 1'b1; rv_keep = 1'b0; rv_pc = 32'h0; target = 32'h0;
    @(posedge clk); #2;
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_pc_stall", {31'h0, pc_stall}, 32'h1);
    step(); step(); #1;
    check("rst_dec_valid", {31'h0, dec_valid}, 32'h0);

    // Streaming fetch from 0x0 with a single-cycle memory
    rst_n = 1'b1; #1;
    check("seq_req0", {31'h0, mem_req}, 32'h1);
    check("seq_addr0", mem_addr, 32'h0);
    step(); #1;
    check("seq_addr1", mem_addr, 32'h2);
    step(); #1;
    check("seq_addr2", mem_addr, 32'h4);
    check("seq_dec_valid", {31'h0, dec_valid}, 32'h1);
    check("seq_head_pc", dec_pc, 32'h0);
    step();
    mem_ack = 1'b0;
    repeat (4) step();
    #1;
    check("seq_drained", {31'h0, dec_valid}, 32'h0);
    check("seq_sb_empty", exp_q.size(), 32'h0);

    // Decode stalled: queue fills to DEPTH, then requests stop
    pc_in = 32'h100; mem_ack = 1'b1; dec_ready = 1'b0;
    repeat (5) step();
    #1;
    check("full_req", {31'h0, mem_req}, 32'h0);
    check("full_stall", {31'h0, pc_stall}, 32'h1);
    check("full_addr", mem_addr, 32'h108);
    step(); step(); #1;
    check("full_hold_req", {31'h0, mem_req}, 32'h0);
    dec_ready = 1'b1; #1;
    check("pop_cycle_req", {31'h0, mem_req}, 32'h0);
    step();
    dec_ready = 1'b0; #1;
    check("refill_req", {31'h0, mem_req}, 32'h1);
    check("refill_addr", mem_addr, 32'h108);
    step(); #1;
    check("refill_single_a", {31'h0, mem_req}, 32'h0);
    step(); #1;
    check("refill_single_b", {31'h0, mem_req}, 32'h0);
    mem_ack = 1'b0; dec_ready = 1'b1;
    repeat (6) step();
    #1;
    check("full_drained", {31'h0, dec_valid}, 32'h0);
    check("full_sb_empty", exp_q.size(), 32'h0);

    // Flush while a request is outstanding: response must be dropped
    pc_in = 32'h10; auto_mem = 1'b0; mem_ack = 1'b1; #1;
    check("drain_req", {31'h0, mem_req}, 32'h1);
    check("drain_addr", mem_addr, 32'h10);
    step();
    flush = 1'b1; target = 32'h40; #1;
    check("flush_req", {31'h0, mem_req}, 32'h0);
    check("flush_stall", {31'h0, pc_stall}, 32'h1);
    step();
    flush = 1'b0; #1;
    check("drain_no_req", {31'h0, mem_req}, 32'h0);
    check("drain_dec_valid", {31'h0, dec_valid}, 32'h0);
    step();
    mem_rvalid = 1'b1; mem_rdata = 16'hDEAD; rv_keep = 1'b0; #1;
    check("drain_rv_req", {31'h0, mem_req}, 32'h0);
    step();
    mem_rvalid = 1'b0; mem_ack = 1'b0; #1;
    check("target_req", {31'h0, mem_req}, 32'h1);
    check("target_addr", mem_addr, 32'h40);
    check("drain_dropped", {31'h0, dec_valid}, 32'h0);
    step(); #1;
    check("drain_still_empty", {31'h0, dec_valid}, 32'h0);
    auto_mem = 1'b1;

    // Flush coinciding with a response and a pop
    pc_in = 32'h200; mem_ack = 1'b1; dec_ready = 1'b0;
    step(); step();
    flush = 1'b1; target = 32'h300; dec_ready = 1'b1; #1;
    check("fr_pre_valid", {31'h0, dec_valid}, 32'h1);
    check("fr_req", {31'h0, mem_req}, 32'h0);
    step();
    flush = 1'b0; dec_ready = 1'b0; mem_ack = 1'b0; #1;
    check("fr_empty", {31'h0, dec_valid}, 32'h0);
    check("fr_idle_req", {31'h0, mem_req}, 32'h1);
    check("fr_addr", mem_addr, 32'h300);
    step(); #1;
    check("fr_no_entry", {31'h0, dec_valid}, 32'h0);
    check("fr_sb_empty", exp_q.size(), 32'h0);

    // Halt: no new requests, queued entries still drain
    mem_ack = 1'b1; dec_ready = 1'b0;
    step(); step(); step();
    halt = 1'b1; #1;
    check("halt_wait_req", {31'h0, mem_req}, 32'h0);
    check("halt_wait_stall", {31'h0, pc_stall}, 32'h1);
    step(); #1;
    check("halt_idle_req", {31'h0, mem_req}, 32'h0);
    check("halt_idle_stall", {31'h0, pc_stall}, 32'h1);
    check("halt_valid", {31'h0, dec_valid}, 32'h1);
    check("halt_head_pc", dec_pc, 32'h300);
    dec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("halt_drain_req", {31'h0, mem_req}, 32'h0);
      step();
    end
    #1;
    check("halt_drained", {31'h0, dec_valid}, 32'h0);
    check("halt_sb_empty", exp_q.size(), 32'h0);
    halt = 1'b0; mem_ack = 1'b0; dec_ready = 1'b0;

    // Reset while a request is outstanding, late response afterwards
    pc_in = 32'h80; auto_mem = 1'b0; mem_ack = 1'b1; #1;
    check("rw_req", {31'h0, mem_req}, 32'h1);
    step();
    rst_n = 1'b0; pc_in = 32'h0; #1;
    check("rw_rst_req", {31'h0, mem_req}, 32'h0);
    check("rw_rst_stall", {31'h0, pc_stall}, 32'h1);
    check("rw_rst_valid", {31'h0, dec_valid}, 32'h0);
    step(); #1;
    check("rw_rst_req2", {31'h0, mem_req}, 32'h0);
    rst_n = 1'b1; mem_ack = 1'b0; mem_rvalid = 1'b1; mem_rdata = 16'hBEEF; rv_keep = 1'b0; #1;
    check("rw_first_req", {31'h0, mem_req}, 32'h1);
    check("rw_first_addr", mem_addr, 32'h0);
    check("rw_valid", {31'h0, dec_valid}, 32'h0);
    step();
    mem_rvalid = 1'b0; #1;
    check("rw_no_push", {31'h0, dec_valid}, 32'h0);
    check("rw_idle_req", {31'h0, mem_req}, 32'h1);
    auto_mem = 1'b1; mem_ack = 1'b1; dec_ready = 1'b1;
    step(); step(); step();
    mem_ack = 1'b0;
    repeat (4) step();
    #1;
    check("rw_drained", {31'h0, dec_valid}, 32'h0);
    check("rw_sb_empty", exp_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
